// File: rtl/camera_drive_pkg.sv
// Shared types for the camera-driven motor controller: decoded steering
// commands, drive FSM states and the flag-to-command decoder.
package camera_drive_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_FWD   = 2'd1,
        CMD_LEFT  = 2'd2,
        CMD_RIGHT = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_FWD   = 3'd1,
        ST_LEFT  = 3'd2,
        ST_RIGHT = 3'd3,
        ST_COAST = 3'd4
    } drive_state_e;

    // Priority decode: centered wins; contradictory turn flags mean "no command".
    function automatic cmd_e decode_cmd(input logic centered,
                                        input logic turn_left,
                                        input logic turn_right);
        cmd_e c;
        if (centered) begin
            c = CMD_FWD;
        end else if (turn_left && !turn_right) begin
            c = CMD_LEFT;
        end else if (turn_right && !turn_left) begin
            c = CMD_RIGHT;
        end else begin
            c = CMD_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/camera_drive_motor_ctrl_pwm_ramp_channel.sv
// One wheel channel: slew-limited applied duty, period-boundary duty latch
// and registered PWM compare against the shared period counter.
module pwm_ramp_channel
    import camera_drive_pkg::*;
#(
    parameter int PWM_PERIOD = 2500,
    parameter int RAMP_STEP  = 25,
    parameter int DW         = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_enable,
    input  logic          i_tick,
    input  logic [DW-1:0] i_pcnt,
    input  logic [DW-1:0] i_target,
    output logic          o_pwm,
    output logic [DW-1:0] o_applied_nxt
);

    localparam int            DW1      = DW + 1;
    localparam logic [DW:0]   STEP_W   = DW1'(RAMP_STEP);
    localparam logic [DW:0]   PERIOD_W = DW1'(PWM_PERIOD);

    logic [DW-1:0] r_applied;
    logic [DW-1:0] r_duty;
    logic          r_pwm;

    logic [DW:0]   w_t;
    logic [DW:0]   w_a;
    logic [DW:0]   w_mag;
    logic [DW:0]   w_step;
    logic [DW:0]   w_sum;
    logic          w_up;
    logic [DW-1:0] w_nxt;
    logic [DW-1:0] w_cmp;

    // Ramp arithmetic one bit wider than the duty so the difference never wraps.
    always_comb begin
        w_t    = ({1'b0, i_target} > PERIOD_W) ? PERIOD_W : {1'b0, i_target};
        w_a    = {1'b0, r_applied};
        w_up   = 1'b0;
        w_mag  = '0;
        if (w_t >= w_a) begin
            w_up  = 1'b1;
            w_mag = w_t - w_a;
        end else begin
            w_up  = 1'b0;
            w_mag = w_a - w_t;
        end
        w_step = (w_mag > STEP_W) ? STEP_W : w_mag;
        w_sum  = w_up ? (w_a + w_step) : (w_a - w_step);
        if (w_sum > PERIOD_W) begin
            w_sum = PERIOD_W;
        end else begin
            w_sum = w_sum;
        end
        if (!i_enable) begin
            w_nxt = '0;
        end else if (i_tick) begin
            w_nxt = w_sum[DW-1:0];
        end else begin
            w_nxt = r_applied;
        end
    end

    // At the period start the fresh applied duty is used directly so the
    // whole period compares against one consistent value.
    always_comb begin
        if (i_pcnt == '0) begin
            w_cmp = r_applied;
        end else begin
            w_cmp = r_duty;
        end
    end

    // Applied duty, period-latched duty and registered pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_applied <= '0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_applied <= w_nxt;
            r_duty    <= w_cmp;
            r_pwm     <= (i_pcnt < w_cmp);
        end
    end

    assign o_pwm         = r_pwm;
    assign o_applied_nxt = w_nxt;

endmodule

// File: rtl/camera_drive_motor_ctrl.sv
// Steering flags -> debounced command -> drive FSM -> per-wheel targets ->
// two slew-limited, glitch-free PWM channels.
module camera_drive_motor_ctrl
    import camera_drive_pkg::*;
#(
    parameter int PWM_PERIOD      = 2500,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int LOST_TIMEOUT    = 25_000_000,
    parameter int DUTY_FWD        = 1500,
    parameter int DUTY_FAST       = 1800,
    parameter int DUTY_SLOW       = 600,
    parameter int RAMP_STEP       = 25,
    parameter int RAMP_DIV        = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       centered,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic       moving,
    output logic [2:0] state
);

    localparam int DW  = $clog2(PWM_PERIOD + 1);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LTW = $clog2(LOST_TIMEOUT + 1);
    localparam int RDW = $clog2(RAMP_DIV + 1);

    localparam logic [DW-1:0]  P_LAST  = DW'(PWM_PERIOD - 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ARM  = DBW'(DEBOUNCE_CYCLES - 2);
    localparam logic [LTW-1:0] LT_LAST = LTW'(LOST_TIMEOUT - 1);
    localparam logic [RDW-1:0] RD_LAST = RDW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]  D_FWD   = DW'(DUTY_FWD);
    localparam logic [DW-1:0]  D_FAST  = DW'(DUTY_FAST);
    localparam logic [DW-1:0]  D_SLOW  = DW'(DUTY_SLOW);

    cmd_e           w_cmd;
    cmd_e           r_cmd_prev;
    cmd_e           r_cmd_stable;
    logic [DBW-1:0] r_db_cnt;
    drive_state_e   r_state;
    drive_state_e   w_state_nxt;
    logic [LTW-1:0] r_coast;
    logic [RDW-1:0] r_div;
    logic           w_tick;
    logic [DW-1:0]  r_pcnt;
    logic [DW-1:0]  w_tgt_l;
    logic [DW-1:0]  w_tgt_r;
    logic [DW-1:0]  r_hold_l;
    logic [DW-1:0]  r_hold_r;
    logic [DW-1:0]  w_nxt_l;
    logic [DW-1:0]  w_nxt_r;
    logic           r_moving;

    assign w_cmd  = decode_cmd(centered, turn_left, turn_right);
    assign w_tick = (r_div == RD_LAST);

    // Debounce: accept a command only after it has been steady for the full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_prev   <= CMD_NONE;
            r_cmd_stable <= CMD_NONE;
            r_db_cnt     <= '0;
        end else begin
            r_cmd_prev <= w_cmd;
            if (w_cmd != r_cmd_prev) begin
                r_db_cnt <= '0;
            end else begin
                if (r_db_cnt != DB_LAST) begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
                if (r_db_cnt >= DB_ARM) begin
                    r_cmd_stable <= w_cmd;
                end
            end
        end
    end

    // Drive FSM next state; enable low overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = ST_STOP;
        end else begin
            case (r_cmd_stable)
                CMD_FWD:   w_state_nxt = ST_FWD;
                CMD_LEFT:  w_state_nxt = ST_LEFT;
                CMD_RIGHT: w_state_nxt = ST_RIGHT;
                CMD_NONE: begin
                    case (r_state)
                        ST_FWD, ST_LEFT, ST_RIGHT: w_state_nxt = ST_COAST;
                        ST_COAST: begin
                            if (r_coast == LT_LAST) begin
                                w_state_nxt = ST_STOP;
                            end else begin
                                w_state_nxt = ST_COAST;
                            end
                        end
                        default:                   w_state_nxt = ST_STOP;
                    endcase
                end
                default:   w_state_nxt = ST_STOP;
            endcase
        end
    end

    // State register and coast timer (timer runs only while coasting).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
            r_coast <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != ST_COAST) begin
                r_coast <= '0;
            end else if (r_coast != LT_LAST) begin
                r_coast <= r_coast + LTW'(1);
            end
        end
    end

    // Per-wheel targets from the state; coasting keeps the last driven targets.
    always_comb begin
        w_tgt_l = '0;
        w_tgt_r = '0;
        case (r_state)
            ST_STOP:  begin w_tgt_l = '0;       w_tgt_r = '0;       end
            ST_FWD:   begin w_tgt_l = D_FWD;    w_tgt_r = D_FWD;    end
            ST_LEFT:  begin w_tgt_l = D_SLOW;   w_tgt_r = D_FAST;   end
            ST_RIGHT: begin w_tgt_l = D_FAST;   w_tgt_r = D_SLOW;   end
            ST_COAST: begin w_tgt_l = r_hold_l; w_tgt_r = r_hold_r; end
            default:  begin w_tgt_l = '0;       w_tgt_r = '0;       end
        endcase
    end

    // Capture targets while not coasting so COAST can replay them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l <= '0;
            r_hold_r <= '0;
        end else if (r_state != ST_COAST) begin
            r_hold_l <= w_tgt_l;
            r_hold_r <= w_tgt_r;
        end
    end

    // Ramp tick divider and shared PWM period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_pcnt <= '0;
        end else begin
            r_div  <= w_tick ? '0 : (r_div + RDW'(1));
            r_pcnt <= (r_pcnt == P_LAST) ? '0 : (r_pcnt + DW'(1));
        end
    end

    pwm_ramp_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DW         (DW)
    ) u_left (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_tick        (w_tick),
        .i_pcnt        (r_pcnt),
        .i_target      (w_tgt_l),
        .o_pwm         (pwm_left),
        .o_applied_nxt (w_nxt_l)
    );

    pwm_ramp_channel #(
        .PWM_PERIOD (PWM_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DW         (DW)
    ) u_right (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_tick        (w_tick),
        .i_pcnt        (r_pcnt),
        .i_target      (w_tgt_r),
        .o_pwm         (pwm_right),
        .o_applied_nxt (w_nxt_r)
    );

    // Moving flag registered alongside the applied duties it summarises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_moving <= 1'b0;
        end else begin
            r_moving <= (w_nxt_l != '0) || (w_nxt_r != '0);
        end
    end

    assign moving = r_moving;
    assign state  = r_state;

endmodule

// File: tb/tb_camera_drive_motor_ctrl.sv
// Directed bench for camera_drive_motor_ctrl with small parameters; a second
// instance runs with the forward duty equal to the full PWM period.
module tb_camera_drive_motor_ctrl;
    import camera_drive_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, turn_left, turn_right, centered;
    logic       pwm_left, pwm_right, moving;
    logic [2:0] state;
    logic       b_enable, b_turn_left, b_turn_right, b_centered;
    logic       b_pwm_left, b_pwm_right, b_moving;
    logic [2:0] b_state;

    int n_checks = 0;
    int n_errors = 0;
    int hi_l, hi_r;
    logic seen;

    always #5 clk = ~clk;

    camera_drive_motor_ctrl #(
        .PWM_PERIOD(10), .DEBOUNCE_CYCLES(4), .LOST_TIMEOUT(20),
        .DUTY_FWD(8), .DUTY_FAST(8), .DUTY_SLOW(2), .RAMP_STEP(2), .RAMP_DIV(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .turn_left(turn_left),
        .turn_right(turn_right), .centered(centered), .pwm_left(pwm_left),
        .pwm_right(pwm_right), .moving(moving), .state(state)
    );

    camera_drive_motor_ctrl #(
        .PWM_PERIOD(10), .DEBOUNCE_CYCLES(4), .LOST_TIMEOUT(20),
        .DUTY_FWD(10), .DUTY_FAST(8), .DUTY_SLOW(2), .RAMP_STEP(2), .RAMP_DIV(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .turn_left(b_turn_left),
        .turn_right(b_turn_right), .centered(b_centered), .pwm_left(b_pwm_left),
        .pwm_right(b_pwm_right), .moving(b_moving), .state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_hi(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cl += int'(pwm_left);
            cr += int'(pwm_right);
        end
    endtask

    task automatic chk_appl(input string tag, input int l, input int r);
        chk({tag, "_appl_l"}, 32'(dut_a.u_left.r_applied), 32'(l));
        chk({tag, "_appl_r"}, 32'(dut_a.u_right.r_applied), 32'(r));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; centered = 1'b1; turn_left = 1'b0; turn_right = 1'b0;
        b_enable = 1'b1; b_centered = 1'b1; b_turn_left = 1'b0; b_turn_right = 1'b0;

        // 1. Reset with centered held, then straight-ahead ramp-up.
        cyc(3);
        chk("rst_pwm_l", 32'(pwm_left), 32'd0);
        chk("rst_pwm_r", 32'(pwm_right), 32'd0);
        chk("rst_state", 32'(state), 32'(ST_STOP));
        chk("rst_moving", 32'(moving), 32'd0);
        rst_n = 1'b1;
        cyc(4);
        chk("deb_still_stop", 32'(state), 32'(ST_STOP));
        cyc(1);
        chk("fwd_after_5", 32'(state), 32'(ST_FWD));
        chk_appl("fwd_start", 0, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk_appl("fwd_ramp", 2 * k, 2 * k);
            chk("fwd_moving", 32'(moving), 32'd1);
        end
        cyc(12);
        count_hi(10, hi_l, hi_r);
        chk("fwd_hi_l", 32'(hi_l), 32'd8);
        chk("fwd_hi_r", 32'(hi_r), 32'd8);

        // 5. Enable drop mid-period at duty 8.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dut_a.r_pcnt == 4'd4) seen = 1'b1;
            else cyc(1);
        end
        chk("en_mid_period", 32'(seen), 32'd1);
        enable = 1'b0;
        cyc(1);
        chk("en_state_stop", 32'(state), 32'(ST_STOP));
        chk_appl("en_zero", 0, 0);
        chk("en_moving", 32'(moving), 32'd0);
        chk("en_pin_still_hi", 32'(pwm_left), 32'd1);
        cyc(11);
        count_hi(10, hi_l, hi_r);
        chk("en_hi_l", 32'(hi_l), 32'd0);
        chk("en_hi_r", 32'(hi_r), 32'd0);
        centered = 1'b0;
        cyc(8);
        enable = 1'b1;
        cyc(3);
        chk("reen_stop", 32'(state), 32'(ST_STOP));

        // 2. Three-cycle centered pulse must be rejected.
        centered = 1'b1;
        cyc(3);
        centered = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (pwm_left || pwm_right || (state != ST_STOP)) seen = 1'b1;
        end
        chk("flicker_quiet", 32'(seen), 32'd0);

        // Back to FWD at full forward duty.
        centered = 1'b1;
        cyc(4);
        chk("refwd_wait", 32'(state), 32'(ST_STOP));
        cyc(1);
        chk("refwd", 32'(state), 32'(ST_FWD));
        cyc(4);
        chk_appl("refwd_duty", 8, 8);

        // 3. Right turn: right wheel slows to DUTY_SLOW, left holds.
        centered = 1'b0;
        turn_right = 1'b1;
        cyc(4);
        chk("right_wait", 32'(state), 32'(ST_FWD));
        cyc(1);
        chk("right_state", 32'(state), 32'(ST_RIGHT));
        chk_appl("right_start", 8, 8);
        cyc(1); chk_appl("right_r6", 8, 6);
        cyc(1); chk_appl("right_r4", 8, 4);
        cyc(1); chk_appl("right_r2", 8, 2);
        cyc(15);
        count_hi(10, hi_l, hi_r);
        chk("right_hi_l", 32'(hi_l), 32'd8);
        chk("right_hi_r", 32'(hi_r), 32'd2);

        // Left turn to set up the illegal-flags case.
        turn_right = 1'b0;
        turn_left = 1'b1;
        cyc(5);
        chk("left_state", 32'(state), 32'(ST_LEFT));
        cyc(6);
        chk_appl("left_duty", 2, 8);

        // 4. Both turn flags: COAST with held targets, STOP after timeout.
        turn_right = 1'b1;
        cyc(4);
        chk("coast_wait", 32'(state), 32'(ST_LEFT));
        cyc(1);
        chk("coast_state", 32'(state), 32'(ST_COAST));
        chk_appl("coast_hold0", 2, 8);
        cyc(19);
        chk("coast_19", 32'(state), 32'(ST_COAST));
        chk_appl("coast_hold19", 2, 8);
        cyc(1);
        chk("coast_to_stop", 32'(state), 32'(ST_STOP));
        chk_appl("stop_first", 2, 8);
        cyc(1); chk_appl("stop_ramp1", 0, 6);
        cyc(1); chk_appl("stop_ramp2", 0, 4);
        cyc(1); chk_appl("stop_ramp3", 0, 2);
        chk("stop_moving_hi", 32'(moving), 32'd1);
        cyc(1); chk_appl("stop_ramp4", 0, 0);
        chk("stop_moving_lo", 32'(moving), 32'd0);

        // 6. Full-period duty on the second instance: pins never drop.
        chk("b_state", 32'(b_state), 32'(ST_FWD));
        chk("b_appl", 32'(dut_b.u_left.r_applied), 32'd10);
        hi_l = 0;
        hi_r = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            hi_l += int'(b_pwm_left);
            hi_r += int'(b_pwm_right);
        end
        chk("b_hi_l", 32'(hi_l), 32'd20);
        chk("b_hi_r", 32'(hi_r), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
